// File: rtl/obstacle_mover.sv
// obstacle_mover: single-sprite animator for the 160x120, 3-bit-colour VGA
// plot interface. It draws a W_SIZE x H_SIZE rectangle, holds it for
// FRAMES_PER_STEP frame ticks, erases it and then steps it along X toward
// END_X. At END_X it either finishes or wraps back to START_X.
//
// Handshake: start is a one-cycle pulse that is honoured only in IDLE or DONE.
// The plot strobe is a write-only valid with no ready. Whenever plot is high,
// x/y/colour describe exactly one pixel to write in that cycle.
module obstacle_mover #(
   parameter int          W_SIZE          = 4,
   parameter int          H_SIZE          = 4,
   parameter int          START_X         = 10,
   parameter int          START_Y         = 58,
   parameter int          END_X           = 100,
   parameter int          STEP_PX         = 1,
   parameter int          CLKS_PER_FRAME  = 833333,
   parameter int          FRAMES_PER_STEP = 15,
   parameter logic [2:0]  COLOUR          = 3'd2,
   parameter logic [2:0]  BG_COLOUR       = 3'd0
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       start,
   input  logic       enable,
   input  logic       loop_en,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic [2:0] colour,
   output logic       plot,
   output logic       busy,
   output logic       finish,
   output logic [7:0] obj_x
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_DRAW  = 3'd1,
      S_WAIT  = 3'd2,
      S_ERASE = 3'd3,
      S_MOVE  = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   // Counter widths come from each counter's terminal value. A minimum of
   // one bit keeps the degenerate size-1 cases legal.
   localparam int PX_W  = (W_SIZE > 1) ? $clog2(W_SIZE) : 1;
   localparam int PY_W  = (H_SIZE > 1) ? $clog2(H_SIZE) : 1;
   localparam int CLK_W = (CLKS_PER_FRAME > 1) ? $clog2(CLKS_PER_FRAME) : 1;
   localparam int FRM_W = $clog2(FRAMES_PER_STEP + 1);

   state_t            r_state;
   state_t            w_state_next;
   logic [7:0]        r_obj_x;
   logic [7:0]        w_obj_x_next;
   logic [PX_W-1:0]   r_px;
   logic [PX_W-1:0]   w_px_next;
   logic [PY_W-1:0]   r_py;
   logic [PY_W-1:0]   w_py_next;
   logic [CLK_W-1:0]  r_clk_cnt;
   logic [CLK_W-1:0]  w_clk_next;
   logic [FRM_W-1:0]  r_frame_cnt;
   logic [FRM_W-1:0]  w_frame_next;
   logic [FRM_W-1:0]  w_frame_inc;
   logic [8:0]        w_step_sum;
   logic              w_row_last;
   logic              w_sweep_last;
   logic              w_sweeping;

   // State and datapath registers, synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_state     <= S_IDLE;
         r_obj_x     <= 8'(START_X);
         r_px        <= '0;
         r_py        <= '0;
         r_clk_cnt   <= '0;
         r_frame_cnt <= '0;
      end else begin
         r_state     <= w_state_next;
         r_obj_x     <= w_obj_x_next;
         r_px        <= w_px_next;
         r_py        <= w_py_next;
         r_clk_cnt   <= w_clk_next;
         r_frame_cnt <= w_frame_next;
      end
   end

   // Next-state logic: pixel sweep, frame timer and sprite stepping.
   always_comb begin
      w_state_next = r_state;
      w_obj_x_next = r_obj_x;
      w_px_next    = r_px;
      w_py_next    = r_py;
      w_clk_next   = r_clk_cnt;
      w_frame_next = r_frame_cnt;
      w_row_last   = (r_px == PX_W'(W_SIZE - 1));
      w_sweep_last = w_row_last && (r_py == PY_W'(H_SIZE - 1));
      w_frame_inc  = r_frame_cnt + 1'b1;
      // The 9-bit sum cannot overflow, so the clamp against END_X is exact.
      w_step_sum   = {1'b0, r_obj_x} + 9'(STEP_PX);

      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_state_next = S_DRAW;
               w_obj_x_next = 8'(START_X);
               w_px_next    = '0;
               w_py_next    = '0;
            end
         end
         S_DRAW, S_ERASE: begin
            if (w_sweep_last) begin
               w_px_next    = '0;
               w_py_next    = '0;
               w_clk_next   = '0;
               w_frame_next = '0;
               w_state_next = (r_state == S_DRAW) ? S_WAIT : S_MOVE;
            end else if (w_row_last) begin
               w_px_next = '0;
               w_py_next = r_py + 1'b1;
            end else begin
               w_px_next = r_px + 1'b1;
            end
         end
         S_WAIT: begin
            // A low enable freezes both counters, which pauses the sprite.
            if (enable) begin
               if (r_clk_cnt == CLK_W'(CLKS_PER_FRAME - 1)) begin
                  w_clk_next   = '0;
                  w_frame_next = w_frame_inc;
                  if (w_frame_inc == FRM_W'(FRAMES_PER_STEP)) begin
                     w_state_next = S_ERASE;
                  end
               end else begin
                  w_clk_next = r_clk_cnt + 1'b1;
               end
            end
         end
         S_MOVE: begin
            if (r_obj_x == 8'(END_X)) begin
               if (loop_en) begin
                  w_obj_x_next = 8'(START_X);
                  w_state_next = S_DRAW;
               end else begin
                  w_state_next = S_DONE;
               end
            end else begin
               w_obj_x_next = (w_step_sum > 9'(END_X)) ? 8'(END_X) : w_step_sum[7:0];
               w_state_next = S_DRAW;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // Plot interface outputs, decoded from registered state only.
   always_comb begin
      w_sweeping = (r_state == S_DRAW) || (r_state == S_ERASE);
      plot       = w_sweeping;
      x          = r_obj_x;
      y          = 7'(START_Y);
      colour     = BG_COLOUR;
      if (w_sweeping) begin
         x = r_obj_x + 8'(r_px);
         y = 7'(START_Y) + 7'(r_py);
      end
      if (r_state == S_DRAW) begin
         colour = COLOUR;
      end
      busy   = (r_state != S_IDLE) && (r_state != S_DONE);
      finish = (r_state == S_DONE);
      obj_x  = r_obj_x;
   end

endmodule

// File: tb/tb_obstacle_mover.sv
// Bench for obstacle_mover: directed scenarios with literal expectations,
// followed by randomized start/enable/loop_en/resetn traffic. A segment-level
// reference model is checked on every cycle.
module tb_obstacle_mover;
  localparam int W   = 4;
  localparam int H   = 4;
  localparam int SX  = 10;
  localparam int SY  = 58;
  localparam int EX  = 13;
  localparam int STP = 2;
  localparam int CPF = 4;
  localparam int FPS = 2;
  localparam int COL = 2;
  localparam int BG  = 0;

  localparam int M_IDLE  = 0;
  localparam int M_DRAW  = 1;
  localparam int M_WAIT  = 2;
  localparam int M_ERASE = 3;
  localparam int M_MOVE  = 4;
  localparam int M_DONE  = 5;

  // clock / reset block
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       enable = 1'b1;
  logic       loop_en = 1'b0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       finish;
  logic [7:0] obj_x;

  obstacle_mover #(
    .W_SIZE(W), .H_SIZE(H), .START_X(SX), .START_Y(SY), .END_X(EX),
    .STEP_PX(STP), .CLKS_PER_FRAME(CPF), .FRAMES_PER_STEP(FPS),
    .COLOUR(3'd2), .BG_COLOUR(3'd0)
  ) dut (
    .clock(clock), .resetn(resetn), .start(start), .enable(enable),
    .loop_en(loop_en), .x(x), .y(y), .colour(colour), .plot(plot),
    .busy(busy), .finish(finish), .obj_x(obj_x)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model. A run is a sequence of segments: a pixel sweep of W*H
  // cycles, a hold of CPF*FPS enabled cycles, an erase sweep and one step
  // cycle. m_n counts progress inside the current segment.
  int m_mode = M_IDLE;
  int m_ox = SX;
  int m_n = 0;

  always @(posedge clock) begin
    if (!resetn) begin
      m_mode = M_IDLE;
      m_ox = SX;
      m_n = 0;
    end else begin
      case (m_mode)
        M_IDLE, M_DONE: if (start) begin m_mode = M_DRAW; m_ox = SX; m_n = 0; end
        M_DRAW: begin m_n++; if (m_n == W * H) begin m_mode = M_WAIT; m_n = 0; end end
        M_WAIT: begin
          if (enable) m_n++;
          if (m_n == CPF * FPS) begin m_mode = M_ERASE; m_n = 0; end
        end
        M_ERASE: begin m_n++; if (m_n == W * H) begin m_mode = M_MOVE; m_n = 0; end end
        default: begin
          if (m_ox == EX) begin
            if (loop_en) begin m_ox = SX; m_mode = M_DRAW; end
            else m_mode = M_DONE;
          end else begin
            m_ox = (m_ox + STP > EX) ? EX : m_ox + STP;
            m_mode = M_DRAW;
          end
        end
      endcase
    end
  end

  // Compare process: the DUT must match the model on every cycle.
  always @(negedge clock) begin
    bit sw;
    sw = (m_mode == M_DRAW) || (m_mode == M_ERASE);
    check("m_plot", plot, sw);
    check("m_x", x, sw ? m_ox + m_n % W : m_ox);
    check("m_y", y, sw ? SY + m_n / W : SY);
    check("m_colour", colour, (m_mode == M_DRAW) ? COL : BG);
    check("m_busy", busy, (m_mode != M_IDLE) && (m_mode != M_DONE));
    check("m_finish", finish, m_mode == M_DONE);
    check("m_obj_x", obj_x, m_ox);
  end

  // driver tasks
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;
  endtask

  logic [7:0] exp_q[$];
  logic [7:0] draw_q[$];

  initial begin
    int cyc;
    bit prev;
    bit saw_finish;

    // Reset, then idle.
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    repeat (20) @(negedge clock);
    check("idle_plot", plot, 0);
    check("idle_busy", busy, 0);
    check("idle_finish", finish, 0);
    check("idle_x", x, 10);
    check("idle_y", y, 58);

    // Full run with loop_en=0.
    loop_en = 1'b0;
    pulse_start();
    cyc = 0; prev = 1'b0; draw_q.delete();
    check("draw0_plot", plot, 1);
    check("draw0_x", x, 10);
    check("draw0_y", y, 58);
    check("draw0_col", colour, 2);
    while (1) begin
      if (plot && colour == 3'd2 && !prev) draw_q.push_back(x);
      prev = plot;
      if (cyc == 15) begin check("draw15_x", x, 13); check("draw15_y", y, 61); end
      if (cyc == 16) check("wait_first_plot", plot, 0);
      if (cyc == 23) check("wait_last_plot", plot, 0);
      if (cyc == 24) begin
        check("erase0_plot", plot, 1);
        check("erase0_col", colour, 0);
        check("erase0_x", x, 10);
      end
      if (finish || cyc >= 500) break;
      @(negedge clock);
      cyc++;
    end
    check("run_len", cyc, 123);
    check("done_busy", busy, 0);
    exp_q = '{8'd10, 8'd12, 8'd13};
    check("draw_count", draw_q.size(), exp_q.size());
    for (int i = 0; i < 3 && i < draw_q.size(); i++) check("draw_pos", draw_q[i], exp_q[i]);

    // Looping run from DONE.
    loop_en = 1'b1;
    pulse_start();
    cyc = 0; prev = 1'b0; saw_finish = 1'b0; draw_q.delete();
    while (draw_q.size() < 4 && cyc < 500) begin
      if (plot && colour == 3'd2 && !prev) draw_q.push_back(x);
      prev = plot;
      if (finish) saw_finish = 1'b1;
      @(negedge clock);
      cyc++;
    end
    check("loop_finish", saw_finish, 0);
    exp_q = '{8'd10, 8'd12, 8'd13, 8'd10};
    check("loop_count", draw_q.size(), 4);
    for (int i = 0; i < 4 && i < draw_q.size(); i++) check("loop_pos", draw_q[i], exp_q[i]);

    // Pause in WAIT, plus an ignored start while busy.
    loop_en = 1'b0;
    do_reset();
    pulse_start();
    for (cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clock);
      if (cyc == 33) check("pause_wait_plot", plot, 0);
      if (cyc == 34) begin
        check("pause_erase_plot", plot, 1);
        check("pause_erase_col", colour, 0);
        check("pause_erase_x", x, 10);
      end
      if (cyc == 18) enable = 1'b0;
      if (cyc == 28) enable = 1'b1;
      if (cyc == 22) start = 1'b1;
      if (cyc == 23) start = 1'b0;
    end

    // Reset during the 5th pixel of DRAW.
    do_reset();
    pulse_start();
    for (cyc = 1; cyc <= 5; cyc++) begin
      @(negedge clock);
      if (cyc == 4) begin
        check("px5_plot", plot, 1);
        check("px5_x", x, 10);
        check("px5_y", y, 59);
        resetn = 1'b0;
      end
      if (cyc == 5) begin
        check("rst_plot", plot, 0);
        check("rst_busy", busy, 0);
        check("rst_obj_x", obj_x, 10);
      end
    end
    resetn = 1'b1;
    @(negedge clock);
    pulse_start();
    check("redraw_plot", plot, 1);
    check("redraw_x", x, 10);
    check("redraw_y", y, 58);
    check("redraw_col", colour, 2);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      start   = ($urandom_range(0, 24) == 0);
      enable  = ($urandom_range(0, 3) != 0);
      loop_en = $urandom_range(0, 1);
      resetn  = ($urandom_range(0, 399) != 0);
    end
    resetn = 1'b1;
    @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
